// File: rtl/vga_stream_sink.sv
// vga_stream_sink
//   Avalon-ST video sink that validates frame framing (SOP/EOP/length),
//   computes a rotate-XOR checksum per frame and counts good frames.
//
//   Optional build macro VGA_STREAM_SINK_MONITOR_EN enables the per-pixel
//   monitor (pix_valid/pix_x/pix_y/pix_data). When it is undefined those
//   ports are tied to zero.
//
// Ports
//   clk, rst            : single clock, asynchronous active-high reset
//   s_data/s_valid/
//   s_startofpacket/
//   s_endofpacket/
//   s_ready             : Avalon-ST sink, s_ready = !hold
//   hold                : backpressure request
//   err_clear           : clears sticky error flags (a same-cycle set wins)
//   frame_done          : one-cycle pulse after the closing beat of a frame
//   frame_ok            : last closed frame had correct length
//   frame_checksum      : checksum of the last closed frame
//   frame_count         : number of good frames, wraps at 16 bits
//   err_no_sop/
//   err_early_sop/
//   err_length          : sticky error flags
//   pix_valid/pix_x/
//   pix_y/pix_data      : per-pixel monitor, one cycle after each in-frame beat
module vga_stream_sink #(
    parameter int VGA_WIDTH  = 800,
    parameter int VGA_HEIGHT = 600,
    parameter int DATA_WIDTH = 30
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_startofpacket,
    input  logic                  s_endofpacket,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic                  hold,
    input  logic                  err_clear,
    output logic                  frame_done,
    output logic                  frame_ok,
    output logic [31:0]           frame_checksum,
    output logic [15:0]           frame_count,
    output logic                  err_no_sop,
    output logic                  err_early_sop,
    output logic                  err_length,
    output logic                  pix_valid,
    output logic [15:0]           pix_x,
    output logic [15:0]           pix_y,
    output logic [DATA_WIDTH-1:0] pix_data
);

    localparam int TOTAL = VGA_WIDTH * VGA_HEIGHT;
    localparam int CNT_W = $clog2(TOTAL + 1);
    localparam logic [CNT_W-1:0] TOTAL_C = CNT_W'(TOTAL);

    typedef enum logic {WAIT_SOP, ACTIVE} state_t;

    state_t           state;
    logic [CNT_W-1:0] pix_cnt;
    logic [31:0]      csum;

    logic             accept;
    logic             in_frame;
    logic [CNT_W-1:0] cnt_nxt;
    logic [31:0]      csum_nxt;
    logic             close;
    logic             close_ok;
    logic             set_no_sop;
    logic             set_early_sop;
    logic             set_length;

    function automatic logic [31:0] csum_step(input logic [31:0] c,
                                              input logic [DATA_WIDTH-1:0] d);
        return {c[30:0], c[31]} ^ 32'(d);
    endfunction

    assign s_ready = ~hold;
    assign accept  = s_valid & s_ready;

    // Beat evaluation: where the accepted beat lands and whether it closes a frame
    always_comb begin
        in_frame = 1'b0;
        cnt_nxt  = pix_cnt;
        csum_nxt = csum;
        if (accept) begin
            if (s_startofpacket) begin
                // SOP always (re)seeds a frame, also when one is open
                in_frame = 1'b1;
                cnt_nxt  = CNT_W'(1);
                csum_nxt = csum_step(32'd0, s_data);
            end else if (state == ACTIVE) begin
                in_frame = 1'b1;
                cnt_nxt  = pix_cnt + 1'b1;
                csum_nxt = csum_step(csum, s_data);
            end
        end
        // A frame that reaches TOTAL without EOP is closed as a length error
        close    = in_frame & (s_endofpacket | (cnt_nxt == TOTAL_C));
        close_ok = in_frame & s_endofpacket & (cnt_nxt == TOTAL_C);
    end

    assign set_no_sop    = accept & ~s_startofpacket & (state == WAIT_SOP);
    assign set_early_sop = accept & s_startofpacket & (state == ACTIVE);
    assign set_length    = close & ~close_ok;

    // Registered frame state and results
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= WAIT_SOP;
            pix_cnt        <= '0;
            csum           <= '0;
            frame_done     <= 1'b0;
            frame_ok       <= 1'b0;
            frame_checksum <= '0;
            frame_count    <= '0;
            err_no_sop     <= 1'b0;
            err_early_sop  <= 1'b0;
            err_length     <= 1'b0;
        end else begin
            frame_done <= close;
            if (close) begin
                state          <= WAIT_SOP;
                pix_cnt        <= '0;
                frame_checksum <= csum_nxt;
                frame_ok       <= close_ok;
                if (close_ok)
                    frame_count <= frame_count + 16'd1;
            end else if (in_frame) begin
                state   <= ACTIVE;
                pix_cnt <= cnt_nxt;
                csum    <= csum_nxt;
            end
            // Sticky flags: a new error in the clearing cycle survives
            err_no_sop    <= (err_no_sop    & ~err_clear) | set_no_sop;
            err_early_sop <= (err_early_sop & ~err_clear) | set_early_sop;
            err_length    <= (err_length    & ~err_clear) | set_length;
        end
    end

`ifdef VGA_STREAM_SINK_MONITOR_EN
    // Monitor stage: position of each in-frame pixel, one cycle behind the beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_valid <= 1'b0;
            pix_x     <= '0;
            pix_y     <= '0;
            pix_data  <= '0;
        end else begin
            pix_valid <= in_frame;
            if (in_frame) begin
                pix_data <= s_data;
                if (s_startofpacket) begin
                    pix_x <= '0;
                    pix_y <= '0;
                end else if (pix_x == 16'(VGA_WIDTH - 1)) begin
                    pix_x <= '0;
                    pix_y <= pix_y + 16'd1;
                end else begin
                    pix_x <= pix_x + 16'd1;
                end
            end
        end
    end
`else
    assign pix_valid = 1'b0;
    assign pix_x     = '0;
    assign pix_y     = '0;
    assign pix_data  = '0;
`endif

endmodule

// File: tb/tb_vga_stream_sink.sv
module tb_vga_stream_sink;

    localparam int W     = 4;
    localparam int H     = 2;
    localparam int DW    = 30;
    localparam int TOTAL = W * H;
`ifdef VGA_STREAM_SINK_MONITOR_EN
    localparam bit MON = 1'b1;
`else
    localparam bit MON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s_data;
    logic          s_startofpacket, s_endofpacket, s_valid, s_ready;
    logic          hold, err_clear;
    logic          frame_done, frame_ok;
    logic [31:0]   frame_checksum;
    logic [15:0]   frame_count;
    logic          err_no_sop, err_early_sop, err_length;
    logic          pix_valid;
    logic [15:0]   pix_x, pix_y;
    logic [DW-1:0] pix_data;

    always #5 clk = ~clk;

    vga_stream_sink #(.VGA_WIDTH(W), .VGA_HEIGHT(H), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_startofpacket(s_startofpacket),
        .s_endofpacket(s_endofpacket), .s_valid(s_valid), .s_ready(s_ready),
        .hold(hold), .err_clear(err_clear),
        .frame_done(frame_done), .frame_ok(frame_ok),
        .frame_checksum(frame_checksum), .frame_count(frame_count),
        .err_no_sop(err_no_sop), .err_early_sop(err_early_sop), .err_length(err_length),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (frame-as-a-list view) ----------------
    bit            m_in_frame;
    logic [DW-1:0] m_q[$];
    logic [31:0]   m_csum;
    bit            m_done, m_ok, m_nosop, m_early, m_len, m_pv;
    logic [15:0]   m_cnt, m_px, m_py;
    logic [DW-1:0] m_pd;

    function automatic logic [31:0] fold_frame();
        logic [31:0] c = 32'd0;
        foreach (m_q[i]) c = {c[30:0], c[31]} ^ 32'(m_q[i]);
        return c;
    endfunction

    task automatic model_reset();
        m_in_frame = 0; m_q.delete(); m_csum = '0; m_done = 0; m_ok = 0;
        m_cnt = '0; m_nosop = 0; m_early = 0; m_len = 0;
        m_pv = 0; m_px = '0; m_py = '0; m_pd = '0;
    endtask

    task automatic model_edge();
        bit was = m_in_frame;
        bit s_no = 0, s_ea = 0, s_le = 0;
        int idx;
        m_done = 0;
        m_pv   = 0;
        if (s_valid && !hold) begin
            if (s_startofpacket) begin
                if (was) s_ea = 1;
                m_q.delete();
                m_q.push_back(s_data);
                m_in_frame = 1;
            end else if (!was) begin
                s_no = 1;
            end else begin
                m_q.push_back(s_data);
            end
            if (s_startofpacket || was) begin
                idx  = m_q.size() - 1;
                m_pv = 1;
                m_px = 16'(idx % W);
                m_py = 16'(idx / W);
                m_pd = s_data;
                if (s_endofpacket || m_q.size() == TOTAL) begin
                    m_done = 1;
                    m_csum = fold_frame();
                    m_ok   = s_endofpacket && (m_q.size() == TOTAL);
                    if (m_ok) m_cnt = m_cnt + 16'd1;
                    else      s_le = 1;
                    m_in_frame = 0;
                end
            end
        end
        m_nosop = (m_nosop && !err_clear) || s_no;
        m_early = (m_early && !err_clear) || s_ea;
        m_len   = (m_len   && !err_clear) || s_le;
    endtask

    task automatic check_outputs();
        chk("frame_done", 32'(frame_done), 32'(m_done));
        chk("frame_ok", 32'(frame_ok), 32'(m_ok));
        chk("frame_checksum", frame_checksum, m_csum);
        chk("frame_count", 32'(frame_count), 32'(m_cnt));
        chk("err_flags", 32'({err_no_sop, err_early_sop, err_length}),
            32'({m_nosop, m_early, m_len}));
        chk("pix_valid", 32'(pix_valid), MON ? 32'(m_pv) : 32'd0);
        chk("pix_x", 32'(pix_x), MON ? 32'(m_px) : 32'd0);
        chk("pix_y", 32'(pix_y), MON ? 32'(m_py) : 32'd0);
        chk("pix_data", 32'(pix_data), MON ? 32'(m_pd) : 32'd0);
    endtask

    // One clock: drive, check s_ready mid-cycle, advance model at the edge, check after
    task automatic step(input bit v, input bit sop, input bit eop, input bit h,
                        input bit clr, input logic [DW-1:0] d);
        s_valid = v; s_startofpacket = sop; s_endofpacket = eop;
        hold = h; err_clear = clr; s_data = d;
        @(negedge clk);
        chk("s_ready", 32'(s_ready), 32'(!h));
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit            v, sop, eop, clr;
        logic [DW-1:0] d;
        bit            e_done, e_ok;
        logic [15:0]   e_cnt;
        logic [2:0]    e_err;   // {no_sop, early_sop, length}
        logic [31:0]   e_csum;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(input bit v, input bit sop, input bit eop, input bit clr,
                                input logic [DW-1:0] d, input bit e_done, input bit e_ok,
                                input logic [15:0] e_cnt, input logic [2:0] e_err,
                                input logic [31:0] e_csum);
        vec_t r;
        r.v = v; r.sop = sop; r.eop = eop; r.clr = clr; r.d = d;
        r.e_done = e_done; r.e_ok = e_ok; r.e_cnt = e_cnt; r.e_err = e_err; r.e_csum = e_csum;
        tbl.push_back(r);
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int            idx, cyc, g;
        bit            h, v, sop, eop, clr;

        // Good 4x2 frame 1..8: checksum 0x16
        for (int i = 1; i <= 8; i++)
            add(1, i == 1, i == 8, 0, DW'(i), i == 8, i == 8,
                (i == 8) ? 16'd1 : 16'd0, 3'b000, (i == 8) ? 32'd22 : 32'd0);
        add(0, 0, 0, 0, '0, 0, 1, 16'd1, 3'b000, 32'd22);
        // Short frame: EOP on beat 6, checksum 0x4
        for (int i = 1; i <= 6; i++)
            add(1, i == 1, i == 6, 0, DW'(i), i == 6, i != 6, 16'd1,
                (i == 6) ? 3'b001 : 3'b000, (i == 6) ? 32'd4 : 32'd22);
        add(0, 0, 0, 1, '0, 0, 0, 16'd1, 3'b000, 32'd4);
        // Two beats without SOP, then a good frame
        add(1, 0, 0, 0, DW'(9), 0, 0, 16'd1, 3'b100, 32'd4);
        add(1, 0, 0, 0, DW'(10), 0, 0, 16'd1, 3'b100, 32'd4);
        for (int i = 1; i <= 8; i++)
            add(1, i == 1, i == 8, 0, DW'(i), i == 8, i == 8,
                (i == 8) ? 16'd2 : 16'd1, 3'b100, (i == 8) ? 32'd22 : 32'd4);
        add(0, 0, 0, 1, '0, 0, 1, 16'd2, 3'b000, 32'd22);
        // Early SOP on beat 3 restarts the frame; 8 clean beats follow
        add(1, 1, 0, 0, DW'(1), 0, 1, 16'd2, 3'b000, 32'd22);
        add(1, 0, 0, 0, DW'(2), 0, 1, 16'd2, 3'b000, 32'd22);
        for (int i = 1; i <= 8; i++)
            add(1, i == 1, i == 8, 0, DW'(i), i == 8, 1,
                (i == 8) ? 16'd3 : 16'd2, 3'b010, 32'd22);

        // Reset state
        rst = 1'b1; s_valid = 0; s_startofpacket = 0; s_endofpacket = 0;
        hold = 0; err_clear = 0; s_data = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_outputs();
        rst = 1'b0;

        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].sop, tbl[i].eop, 0, tbl[i].clr, tbl[i].d);
            chk($sformatf("tbl%0d_done", i), 32'(frame_done), 32'(tbl[i].e_done));
            chk($sformatf("tbl%0d_ok", i), 32'(frame_ok), 32'(tbl[i].e_ok));
            chk($sformatf("tbl%0d_count", i), 32'(frame_count), 32'(tbl[i].e_cnt));
            chk($sformatf("tbl%0d_err", i),
                32'({err_no_sop, err_early_sop, err_length}), 32'(tbl[i].e_err));
            chk($sformatf("tbl%0d_csum", i), frame_checksum, tbl[i].e_csum);
        end

        // Backpressure toggled every 2 cycles with s_valid held
        idx = 1; cyc = 0;
        while (idx <= 8 && cyc < 64) begin
            h = ((cyc / 2) % 2) == 1;
            step(1, idx == 1, idx == 8, h, 0, DW'(idx));
            if (!h) idx++;
            cyc++;
        end
        chk("hold_beats", 32'(idx), 32'd9);
        chk("hold_done", 32'(frame_done), 32'd1);
        chk("hold_csum", frame_checksum, 32'd22);
        chk("hold_count", 32'(frame_count), 32'd4);

        // One-pixel SOP+EOP frame is a length error
        step(1, 1, 1, 0, 0, DW'(5));
        chk("onepix_done", 32'(frame_done), 32'd1);
        chk("onepix_ok", 32'(frame_ok), 32'd0);
        chk("onepix_len", 32'(err_length), 32'd1);
        chk("onepix_csum", frame_checksum, 32'd5);

        // Clear together with a new error: the new flag survives
        step(1, 0, 0, 0, 1, DW'(7));
        chk("clr_set_wins", 32'({err_no_sop, err_early_sop, err_length}), 32'b100);

        // Full length without EOP closes as a length error
        for (int i = 1; i <= 8; i++) step(1, i == 1, 0, 0, 0, DW'(i));
        chk("noeop_done", 32'(frame_done), 32'd1);
        chk("noeop_ok", 32'(frame_ok), 32'd0);
        chk("noeop_len", 32'(err_length), 32'd1);
        chk("noeop_count", 32'(frame_count), 32'd4);
        step(1, 0, 0, 0, 1, DW'(9));
        chk("after_noeop_flags", 32'({err_no_sop, err_early_sop, err_length}), 32'b100);

        // Reset in the middle of a frame
        step(1, 1, 0, 0, 0, DW'(1));
        step(1, 0, 0, 0, 0, DW'(2));
        step(1, 0, 0, 0, 0, DW'(3));
        s_valid = 0; hold = 1; rst = 1'b1;
        model_reset();
        #1;
        check_outputs();
        chk("rst_ready_hold", 32'(s_ready), 32'd0);
        hold = 0;
        #1;
        chk("rst_ready_nohold", 32'(s_ready), 32'd1);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        step(0, 0, 0, 0, 0, '0);
        chk("rst_no_done", 32'(frame_done), 32'd0);
        chk("rst_count", 32'(frame_count), 32'd0);
        step(1, 0, 1, 0, 0, DW'(4));
        chk("rst_then_nosop", 32'(err_no_sop), 32'd1);

        // Randomized traffic, mostly well-formed frames with occasional faults
        g = 0;
        for (int n = 0; n < 3000; n++) begin
            v   = $urandom_range(0, 3) != 0;
            h   = $urandom_range(0, 3) == 0;
            sop = (g == 0);
            eop = (g == TOTAL - 1);
            if ($urandom_range(0, 19) == 0) sop = !sop;
            if ($urandom_range(0, 19) == 0) eop = !eop;
            clr = $urandom_range(0, 29) == 0;
            step(v, sop, eop, h, clr, DW'($urandom));
            if (v && !h) g = (g == TOTAL - 1) ? 0 : g + 1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
